// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// Define MC_CU_LLSC_EN to enable LL/SC link tracking; otherwise LL acts as LW and SC as SW.
module mc_control_unit #(
   parameter int WORD_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] instr,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              zero,
   input  logic              snoop_inv,
   output logic              iREN,
   output logic              dREN,
   output logic              dWEN,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic              RegWrite,
   output logic              MemToReg,
   output logic              ALUSrc,
   output logic              LUI,
   output logic              datomic,
   output logic [1:0]        PCSrc,
   output logic [1:0]        RegDst,
   output logic              SignExtend,
   output logic [3:0]        ALUOp,
   output logic              sc_success,
   output logic              Halt,
   output logic              fault,
   output logic [2:0]        state
);
`ifdef MC_CU_LLSC_EN
   localparam bit LLSC = 1'b1;
`else
   localparam bit LLSC = 1'b0;
`endif
   localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
      OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
      OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b,
      OP_LL = 6'h30, OP_SC = 6'h38, OP_HALT = 6'h3f;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21,
      F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
      F_SLT = 6'h2a, F_SLTU = 6'h2b;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT} state_t;
   typedef enum logic [3:0] {ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU} aluop_t;
   typedef enum logic [3:0] {C_NOP, C_ALU, C_BR, C_J, C_JAL, C_JR, C_LD, C_ST, C_SC, C_HALT} cls_t;
   state_t            st;
   logic [WORD_W-1:0] ir;
   logic [CW-1:0]     cnt;
   logic              link, sc_ok, tmo, sc_skip, unused;
   logic [5:0]        op, fn;
   cls_t              cls;
   aluop_t            d_alu;
   logic              d_src, d_sext, d_lui;
   assign op      = ir[31:26];
   assign fn      = ir[5:0];
   assign tmo     = TIMEOUT_CYC > 0 && cnt == LIM;
   assign sc_skip = cls == C_SC && !link;
   assign unused  = ^{ir, snoop_inv};
   always_comb begin
      cls    = C_NOP;
      d_alu  = ALU_ADD;
      d_src  = 1'b0;
      d_sext = 1'b1;
      d_lui  = 1'b0;
      case (op)
         OP_R: begin
            cls = C_ALU;
            case (fn)
               F_SLL:         d_alu = ALU_SLL;
               F_SRL:         d_alu = ALU_SRL;
               F_ADD, F_ADDU: d_alu = ALU_ADD;
               F_SUB, F_SUBU: d_alu = ALU_SUB;
               F_AND:         d_alu = ALU_AND;
               F_OR:          d_alu = ALU_OR;
               F_XOR:         d_alu = ALU_XOR;
               F_NOR:         d_alu = ALU_NOR;
               F_SLT:         d_alu = ALU_SLT;
               F_SLTU:        d_alu = ALU_SLTU;
               F_JR:          cls = C_JR;
               default:       cls = C_NOP;
            endcase
         end
         OP_J:                      cls = C_J;
         OP_JAL:                    cls = C_JAL;
         OP_BEQ, OP_BNE:            begin cls = C_BR; d_alu = ALU_SUB; end
         OP_ADDI, OP_ADDIU:         begin cls = C_ALU; d_src = 1'b1; end
         OP_SLTI:                   begin cls = C_ALU; d_src = 1'b1; d_alu = ALU_SLT; end
         OP_SLTIU:                  begin cls = C_ALU; d_src = 1'b1; d_alu = ALU_SLTU; end
         OP_ANDI:                   begin cls = C_ALU; d_src = 1'b1; d_sext = 1'b0; d_alu = ALU_AND; end
         OP_ORI:                    begin cls = C_ALU; d_src = 1'b1; d_sext = 1'b0; d_alu = ALU_OR; end
         OP_XORI:                   begin cls = C_ALU; d_src = 1'b1; d_sext = 1'b0; d_alu = ALU_XOR; end
         OP_LUI:                    begin cls = C_ALU; d_src = 1'b1; d_lui = 1'b1; end
         OP_LW, OP_LL:              begin cls = C_LD; d_src = 1'b1; end
         OP_SW:                     begin cls = C_ST; d_src = 1'b1; end
         OP_SC:                     begin cls = LLSC ? C_SC : C_ST; d_src = 1'b1; end
         OP_HALT:                   cls = C_HALT;
         default:                   cls = C_NOP;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         st    <= S_FETCH;
         ir    <= '0;
         cnt   <= '0;
         link  <= 1'b0;
         sc_ok <= 1'b0;
      end else begin
         cnt <= '0;
         case (st)
            S_FETCH:
               if (ihit) begin
                  ir <= instr;
                  st <= S_DECODE;
               end else if (tmo) st <= S_FAULT;
               else cnt <= cnt + 1'b1;
            S_DECODE: st <= cls == C_HALT ? S_HALT : cls == C_NOP ? S_FETCH : S_EXEC;
            S_EXEC:   st <= cls == C_ALU ? S_WB : cls inside {C_LD, C_ST, C_SC} ? S_MEM : S_FETCH;
            S_MEM:
               // an unlinked SC never touches memory and reports failure
               if (sc_skip) begin
                  st    <= S_WB;
                  sc_ok <= 1'b0;
               end else if (dhit) begin
                  st    <= cls == C_ST ? S_FETCH : S_WB;
                  sc_ok <= 1'b1;
               end else if (tmo) st <= S_FAULT;
               else cnt <= cnt + 1'b1;
            S_WB:     st <= S_FETCH;
            default:  st <= st;
         endcase
`ifdef MC_CU_LLSC_EN
         link <= (st == S_MEM && op == OP_LL && dhit) ||
                 (link && !snoop_inv && !(st == S_MEM && cls == C_SC && dhit));
`endif
      end
   end
   always_comb begin
      iREN       = st == S_FETCH;
      IRWrite    = iREN && ihit;
      PCWrite    = IRWrite;
      PCSrc      = 2'd0;
      dREN       = 1'b0;
      dWEN       = 1'b0;
      RegWrite   = 1'b0;
      MemToReg   = 1'b0;
      ALUSrc     = 1'b0;
      LUI        = 1'b0;
      datomic    = 1'b0;
      RegDst     = 2'd0;
      SignExtend = 1'b1;
      ALUOp      = ALU_ADD;
      sc_success = 1'b0;
      if (st == S_EXEC) begin
         ALUOp      = d_alu;
         ALUSrc     = d_src;
         SignExtend = d_sext;
         LUI        = d_lui;
         PCWrite    = cls == C_BR ? zero ^ (op == OP_BNE) : cls inside {C_J, C_JAL, C_JR};
         PCSrc      = cls == C_BR ? 2'd1 : cls == C_JR ? 2'd3 : cls inside {C_J, C_JAL} ? 2'd2 : 2'd0;
         RegWrite   = cls == C_JAL;
         RegDst     = cls == C_JAL ? 2'd2 : 2'd0;
      end
      if (st == S_MEM) begin
         dREN    = cls == C_LD;
         dWEN    = cls == C_ST || (cls == C_SC && link);
         datomic = LLSC && (op == OP_LL || cls == C_SC);
      end
      if (st == S_WB) begin
         RegWrite   = 1'b1;
         RegDst     = {1'b0, op == OP_R};
         MemToReg   = cls == C_LD;
         sc_success = cls == C_SC && sc_ok;
      end
   end
   assign Halt  = st inside {S_HALT, S_FAULT};
   assign fault = st == S_FAULT;
   assign state = st;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized instruction stream against a per-instruction cycle/strobe model,
// plus directed reset, timeout and LL/SC scenarios.
module tb_mc_control_unit;
   localparam int TMO = 4;
`ifdef MC_CU_LLSC_EN
   localparam bit LLSC = 1'b1;
`else
   localparam bit LLSC = 1'b0;
`endif
   localparam logic [3:0] K_NOP = 4'd0, K_ALU = 4'd1, K_BR = 4'd2, K_J = 4'd3, K_JAL = 4'd4,
      K_JR = 4'd5, K_LD = 4'd6, K_ST = 4'd7, K_SC = 4'd8, K_HALT = 4'd9;
   localparam logic [3:0] A_SLL = 4'd0, A_SRL = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3, A_AND = 4'd4,
      A_OR = 4'd5, A_XOR = 4'd6, A_NOR = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;
   localparam int NT = 33;
   typedef struct packed {
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] cls;
      logic [3:0] alu;
      logic       src;
      logic       sext;
      logic       lui;
   } ent_t;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] instr = '0;
   logic        ihit = 1'b0, dhit = 1'b0, zero = 1'b0, snoop_inv = 1'b0;
   logic        iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite, MemToReg, ALUSrc, LUI, datomic;
   logic [1:0]  PCSrc, RegDst;
   logic        SignExtend, sc_success, Halt, fault;
   logic [3:0]  ALUOp;
   logic [2:0]  state;
   ent_t        tab [NT];
   int          checks = 0, errors = 0;
   bit          link = 1'b0;
   mc_control_unit #(.WORD_W(32), .TIMEOUT_CYC(TMO)) dut (
      .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
      .snoop_inv(snoop_inv), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .LUI(LUI),
      .datomic(datomic), .PCSrc(PCSrc), .RegDst(RegDst), .SignExtend(SignExtend), .ALUOp(ALUOp),
      .sc_success(sc_success), .Halt(Halt), .fault(fault), .state(state)
   );
   always #5 CLK = ~CLK;
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic void load_tab();
      tab[0]  = '{6'h00, 6'h20, K_ALU, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[1]  = '{6'h00, 6'h21, K_ALU, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[2]  = '{6'h00, 6'h22, K_ALU, A_SUB, 1'b0, 1'b1, 1'b0};
      tab[3]  = '{6'h00, 6'h23, K_ALU, A_SUB, 1'b0, 1'b1, 1'b0};
      tab[4]  = '{6'h00, 6'h24, K_ALU, A_AND, 1'b0, 1'b1, 1'b0};
      tab[5]  = '{6'h00, 6'h25, K_ALU, A_OR, 1'b0, 1'b1, 1'b0};
      tab[6]  = '{6'h00, 6'h26, K_ALU, A_XOR, 1'b0, 1'b1, 1'b0};
      tab[7]  = '{6'h00, 6'h27, K_ALU, A_NOR, 1'b0, 1'b1, 1'b0};
      tab[8]  = '{6'h00, 6'h2a, K_ALU, A_SLT, 1'b0, 1'b1, 1'b0};
      tab[9]  = '{6'h00, 6'h2b, K_ALU, A_SLTU, 1'b0, 1'b1, 1'b0};
      tab[10] = '{6'h00, 6'h00, K_ALU, A_SLL, 1'b0, 1'b1, 1'b0};
      tab[11] = '{6'h00, 6'h02, K_ALU, A_SRL, 1'b0, 1'b1, 1'b0};
      tab[12] = '{6'h00, 6'h08, K_JR, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[13] = '{6'h00, 6'h3f, K_NOP, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[14] = '{6'h02, 6'h00, K_J, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[15] = '{6'h03, 6'h00, K_JAL, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[16] = '{6'h04, 6'h00, K_BR, A_SUB, 1'b0, 1'b1, 1'b0};
      tab[17] = '{6'h05, 6'h00, K_BR, A_SUB, 1'b0, 1'b1, 1'b0};
      tab[18] = '{6'h08, 6'h00, K_ALU, A_ADD, 1'b1, 1'b1, 1'b0};
      tab[19] = '{6'h09, 6'h00, K_ALU, A_ADD, 1'b1, 1'b1, 1'b0};
      tab[20] = '{6'h0a, 6'h00, K_ALU, A_SLT, 1'b1, 1'b1, 1'b0};
      tab[21] = '{6'h0b, 6'h00, K_ALU, A_SLTU, 1'b1, 1'b1, 1'b0};
      tab[22] = '{6'h0c, 6'h00, K_ALU, A_AND, 1'b1, 1'b0, 1'b0};
      tab[23] = '{6'h0d, 6'h00, K_ALU, A_OR, 1'b1, 1'b0, 1'b0};
      tab[24] = '{6'h0e, 6'h00, K_ALU, A_XOR, 1'b1, 1'b0, 1'b0};
      tab[25] = '{6'h0f, 6'h00, K_ALU, A_ADD, 1'b1, 1'b1, 1'b1};
      tab[26] = '{6'h23, 6'h00, K_LD, A_ADD, 1'b1, 1'b1, 1'b0};
      tab[27] = '{6'h2b, 6'h00, K_ST, A_ADD, 1'b1, 1'b1, 1'b0};
      tab[28] = '{6'h30, 6'h00, K_LD, A_ADD, 1'b1, 1'b1, 1'b0};
      tab[29] = '{6'h38, 6'h00, K_SC, A_ADD, 1'b1, 1'b1, 1'b0};
      tab[30] = '{6'h3f, 6'h00, K_HALT, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[31] = '{6'h3e, 6'h00, K_NOP, A_ADD, 1'b0, 1'b1, 1'b0};
      tab[32] = '{6'h01, 6'h00, K_NOP, A_ADD, 1'b0, 1'b1, 1'b0};
   endfunction
   task automatic do_reset();
      RST = 1'b1; ihit = 1'b0; dhit = 1'b0; snoop_inv = 1'b0; zero = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      link = 1'b0;
      #1;
      check("rst_state", state, 0);
      check("rst_iREN", iREN, 1);
      check("rst_IRWrite", IRWrite, 0);
      check("rst_PCWrite", PCWrite, 0);
      check("rst_RegWrite", RegWrite, 0);
      check("rst_dREN", dREN, 0);
      check("rst_dWEN", dWEN, 0);
      check("rst_SignExtend", SignExtend, 1);
      check("rst_ALUOp", ALUOp, A_ADD);
      check("rst_Halt", Halt, 0);
      check("rst_fault", fault, 0);
   endtask
   // Runs one instruction from FETCH and compares its duration and strobe activity with the model.
   task automatic run_instr(input int idx, input bit snp, input int fw, input int fd);
      ent_t e;
      logic [31:0] w;
      logic [3:0] k, alu;
      logic [1:0] pcs, rd;
      bit z, taken, lk, src, sx, lu;
      int iw, dw, t, n_ir, n_pc, n_rw, n_dr, n_dw, n_m2r, n_sc, n_at;
      int e_t, e_pc, e_pcs, e_rw, e_rd, e_dr, e_dw, e_at;
      e = tab[idx];
      w = $urandom;
      w[31:26] = e.op;
      if (e.op == 6'h00) w[5:0] = e.fn;
      iw = fw < 0 ? $urandom_range(0, TMO - 1) : fw;
      dw = fd < 0 ? $urandom_range(0, TMO - 1) : fd;
      z = 1'($urandom_range(0, 1));
      k = (!LLSC && e.cls == K_SC) ? K_ST : e.cls;
      if (snp) link = 1'b0;
      lk = LLSC && link;
      taken = z ^ (e.op == 6'h05);
      case (k)
         K_NOP, K_HALT:         e_t = iw + 2;
         K_ALU:                 e_t = iw + 4;
         K_LD:                  e_t = iw + 5 + dw;
         K_ST:                  e_t = iw + 4 + dw;
         K_SC:                  e_t = lk ? iw + 5 + dw : iw + 5;
         default:               e_t = iw + 3;
      endcase
      e_pc  = 1 + ((k == K_BR) ? int'(taken) : int'(k inside {K_J, K_JAL, K_JR}));
      e_pcs = (k == K_BR) ? int'(taken) : (k inside {K_J, K_JAL}) ? 2 : (k == K_JR) ? 3 : 0;
      e_rw  = int'(k inside {K_ALU, K_LD, K_JAL, K_SC});
      e_rd  = (k == K_ALU && e.op == 6'h00) ? 1 : (k == K_JAL) ? 2 : 0;
      e_dr  = (k == K_LD) ? dw + 1 : 0;
      e_dw  = (k == K_ST || (k == K_SC && lk)) ? dw + 1 : 0;
      e_at  = (LLSC && (e.op == 6'h30 || k == K_SC)) ? ((k == K_SC && !lk) ? 1 : dw + 1) : 0;
      {t, n_ir, n_pc, n_rw, n_dr, n_dw, n_m2r, n_sc, n_at} = '0;
      {pcs, rd, alu, src, sx, lu} = '0;
      for (int c = 0; c < 60 && t == 0; c++) begin
         ihit = c == iw;
         dhit = c == iw + 3 + dw;
         zero = z;
         snoop_inv = snp && c == 0;
         instr = (c <= iw) ? w : $urandom;
         #1;
         n_ir  += int'(iREN);
         n_dr  += int'(dREN);
         n_dw  += int'(dWEN);
         n_m2r += int'(MemToReg);
         n_sc  += int'(sc_success);
         n_at  += int'(datomic);
         if (PCWrite) begin n_pc++; pcs = PCSrc; end
         if (RegWrite) begin n_rw++; rd = RegDst; end
         if (state == 3'd2) begin alu = ALUOp; src = ALUSrc; sx = SignExtend; lu = LUI; end
         @(posedge CLK); #1;
         if (c > iw && state inside {3'd0, 3'd5, 3'd6}) t = c + 1;
      end
      ihit = 1'b0; dhit = 1'b0; snoop_inv = 1'b0;
      check($sformatf("cycles[%0d]", idx), t, e_t);
      check($sformatf("end_state[%0d]", idx), state, (k == K_HALT) ? 5 : 0);
      check($sformatf("iREN_cyc[%0d]", idx), n_ir, iw + 1);
      check($sformatf("PCWrite_cyc[%0d]", idx), n_pc, e_pc);
      check($sformatf("PCSrc[%0d]", idx), pcs, e_pcs);
      check($sformatf("RegWrite_cyc[%0d]", idx), n_rw, e_rw);
      check($sformatf("RegDst[%0d]", idx), rd, e_rd);
      check($sformatf("dREN_cyc[%0d]", idx), n_dr, e_dr);
      check($sformatf("dWEN_cyc[%0d]", idx), n_dw, e_dw);
      check($sformatf("MemToReg_cyc[%0d]", idx), n_m2r, (k == K_LD) ? 1 : 0);
      check($sformatf("sc_success_cyc[%0d]", idx), n_sc, (k == K_SC && lk) ? 1 : 0);
      check($sformatf("datomic_cyc[%0d]", idx), n_at, e_at);
      if (!(k inside {K_NOP, K_HALT})) begin
         check($sformatf("ALUOp[%0d]", idx), alu, e.alu);
         check($sformatf("ALUSrc[%0d]", idx), src, e.src);
         check($sformatf("SignExtend[%0d]", idx), sx, e.sext);
         check($sformatf("LUI[%0d]", idx), lu, e.lui);
      end
      if (LLSC && e.op == 6'h30) link = 1'b1;
      if (k == K_SC) link = 1'b0;
      if (k == K_HALT) begin
         check("halt_Halt", Halt, 1);
         check("halt_fault", fault, 0);
         do_reset();
      end
   endtask
   initial begin
      load_tab();
      do_reset();
      // instruction fetch never completes
      repeat (3) begin @(posedge CLK); #1; end
      check("ftmo_still_fetch", state, 0);
      @(posedge CLK); #1;
      check("ftmo_state", state, 6);
      check("ftmo_Halt", Halt, 1);
      check("ftmo_fault", fault, 1);
      check("ftmo_iREN", iREN, 0);
      repeat (4) begin @(posedge CLK); #1; end
      check("ftmo_sticky", state, 6);
      do_reset();
      // data access never completes
      instr = {6'h23, 26'h0};
      ihit = 1'b1;
      @(posedge CLK); #1;
      ihit = 1'b0;
      repeat (5) begin @(posedge CLK); #1; end
      #1;
      check("mtmo_still_mem", state, 3);
      check("mtmo_dREN", dREN, 1);
      @(posedge CLK); #1;
      check("mtmo_state", state, 6);
      check("mtmo_dREN_off", dREN, 0);
      check("mtmo_dWEN_off", dWEN, 0);
      check("mtmo_fault", fault, 1);
      do_reset();
      // reset in the middle of a store handshake
      instr = {6'h2b, 26'h0};
      ihit = 1'b1;
      @(posedge CLK); #1;
      ihit = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end
      #1;
      check("rmem_state", state, 3);
      check("rmem_dWEN", dWEN, 1);
      RST = 1'b1;
      dhit = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      dhit = 1'b0;
      #1;
      check("rmem_state_after", state, 0);
      check("rmem_dWEN_after", dWEN, 0);
      check("rmem_iREN_after", iREN, 1);
      link = 1'b0;
      run_instr(0, 1'b0, 0, 0);
      run_instr(26, 1'b0, 0, 3);
      run_instr(26, 1'b0, TMO - 1, TMO - 1);
      run_instr(27, 1'b0, 0, 0);
      run_instr(17, 1'b0, 0, 0);
      run_instr(28, 1'b0, 0, 0);
      run_instr(29, 1'b1, 0, 0);
      run_instr(28, 1'b0, 1, 2);
      run_instr(29, 1'b0, 0, 1);
      run_instr(29, 1'b0, 0, 0);
      for (int n = 0; n < 200; n++)
         run_instr($urandom_range(0, NT - 1), $urandom_range(0, 7) == 0, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
